// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_ctrl_pkg;

   localparam logic [31:0] HARDCODED_MTVEC  = 32'h8000_0004;

   localparam logic [31:0] M_INSTR_MISALIGN = 32'd0;
   localparam logic [31:0] M_ILL_INSTR      = 32'd2;
   localparam logic [31:0] M_BREAKPOINT     = 32'd3;
   localparam logic [31:0] M_ECALL_M        = 32'd11;
   localparam logic [31:0] M_TIMER_INT      = 32'h8000_0007;
   localparam logic [31:0] M_EXT_INT        = 32'h8000_000B;

   typedef enum logic [1:0] {IDLE, SAVE, RESTORE, REDIRECT} trap_state_t;
   typedef enum logic [1:0] {EV_NONE, EV_TRAP, EV_MRET} trap_event_t;

endpackage

// File: rtl/trap_ctrl_cause_sel.sv
// Priority select among exception, external/timer interrupt and MRET at a commit boundary.
module trap_cause_sel
   import trap_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            exc_valid_i,
   input  logic [XLEN-1:0] exc_cause_i,
   input  logic            meip_i,
   input  logic            meie_i,
   input  logic            mtip_i,
   input  logic            mtie_i,
   input  logic            mie_i,
   input  logic            mret_i,
   output trap_event_t     kind_o,
   output logic [XLEN-1:0] cause_o,
   output logic            is_int_o
);

   always_comb begin
      kind_o   = EV_NONE;
      cause_o  = '0;
      is_int_o = 1'b0;
      if (exc_valid_i) begin
         kind_o  = EV_TRAP;
         cause_o = exc_cause_i;
      end else if (meip_i && meie_i && mie_i) begin
         kind_o   = EV_TRAP;
         cause_o  = XLEN'(M_EXT_INT);
         is_int_o = 1'b1;
      end else if (mtip_i && mtie_i && mie_i) begin
         kind_o   = EV_TRAP;
         cause_o  = XLEN'(M_TIMER_INT);
         is_int_o = 1'b1;
      end else if (mret_i) begin
         kind_o = EV_MRET;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / MRET sequencer: one CSR-write cycle, then one fetch-redirect cycle.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int              XLEN  = 32,
   parameter logic [XLEN-1:0] MTVEC = XLEN'(HARDCODED_MTVEC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid_i,
   input  logic [XLEN-1:0] instr_pc_i,
   input  logic            exc_valid_i,
   input  logic [XLEN-1:0] exc_cause_i,
   input  logic [XLEN-1:0] exc_tval_i,
   input  logic            mret_i,
   input  logic            meip_i,
   input  logic            mtip_i,
   input  logic            mstatus_mie_i,
   input  logic            mstatus_mpie_i,
   input  logic            mie_meie_i,
   input  logic            mie_mtie_i,
   input  logic [XLEN-1:0] mepc_i,
   output logic            csr_we_o,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] mcause_o,
   output logic [XLEN-1:0] mtval_o,
   output logic            mstatus_mie_o,
   output logic            mstatus_mpie_o,
   output logic [1:0]      mstatus_mpp_o,
   output logic            stall_o,
   output logic            flush_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   trap_state_t     state_q;
   trap_event_t     kind;
   logic [XLEN-1:0] cause;
   logic            is_int;
   logic [XLEN-1:0] target_q;

   trap_cause_sel #(.XLEN(XLEN)) u_sel (
      .exc_valid_i (exc_valid_i),
      .exc_cause_i (exc_cause_i),
      .meip_i      (meip_i),
      .meie_i      (mie_meie_i),
      .mtip_i      (mtip_i),
      .mtie_i      (mie_mtie_i),
      .mie_i       (mstatus_mie_i),
      .mret_i      (mret_i),
      .kind_o      (kind),
      .cause_o     (cause),
      .is_int_o    (is_int)
   );

   assign mstatus_mpp_o = 2'b11;

   // Outputs are registered: each state's outputs are loaded on the edge that enters it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         target_q         <= '0;
         csr_we_o         <= 1'b0;
         mepc_o           <= '0;
         mcause_o         <= '0;
         mtval_o          <= '0;
         mstatus_mie_o    <= 1'b0;
         mstatus_mpie_o   <= 1'b0;
         stall_o          <= 1'b0;
         flush_o          <= 1'b0;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
      end else begin
         csr_we_o         <= 1'b0;
         mepc_o           <= '0;
         mcause_o         <= '0;
         mtval_o          <= '0;
         mstatus_mie_o    <= 1'b0;
         mstatus_mpie_o   <= 1'b0;
         stall_o          <= 1'b0;
         flush_o          <= 1'b0;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
         case (state_q)
            IDLE: begin
               if (instr_valid_i && kind == EV_TRAP) begin
                  state_q        <= SAVE;
                  target_q       <= MTVEC;
                  csr_we_o       <= 1'b1;
                  mepc_o         <= {instr_pc_i[XLEN-1:2], 2'b00};
                  mcause_o       <= cause;
                  mtval_o        <= is_int ? '0 : exc_tval_i;
                  mstatus_mpie_o <= mstatus_mie_i;
                  stall_o        <= 1'b1;
               end else if (instr_valid_i && kind == EV_MRET) begin
                  state_q        <= RESTORE;
                  target_q       <= mepc_i;
                  csr_we_o       <= 1'b1;
                  mepc_o         <= {mepc_i[XLEN-1:2], 2'b00};
                  mstatus_mie_o  <= mstatus_mpie_i;
                  mstatus_mpie_o <= 1'b1;
                  stall_o        <= 1'b1;
               end
            end
            SAVE, RESTORE: begin
               state_q          <= REDIRECT;
               stall_o          <= 1'b1;
               flush_o          <= 1'b1;
               redirect_valid_o <= 1'b1;
               redirect_pc_o    <= target_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter MTVEC, default 32'h8000_0004 (package HARDCODED_MTVEC), trap handler entry PC.
REQ-002 Parameter XLEN, default 32, data/address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 instr_valid_i  in  1  instruction at commit boundary this cycle.
REQ-006 instr_pc_i  in  XLEN  PC of committing instruction.
REQ-007 exc_valid_i  in  1  committing instruction raised a synchronous exception.
REQ-008 exc_cause_i  in  XLEN  exception code (package M_* constant).
REQ-009 exc_tval_i  in  XLEN  trap value for exception.
REQ-010 mret_i  in  1  committing instruction is MRET.
REQ-011 meip_i / mtip_i  in  1 each  external / timer interrupt pending.
REQ-012 mstatus_mie_i / mstatus_mpie_i  in  1 each  current mstatus.MIE / MPIE.
REQ-013 mie_meie_i / mie_mtie_i  in  1 each  current mie.MEIE / MTIE.
REQ-014 mepc_i  in  XLEN  current mepc (MRET target).
REQ-015 csr_we_o  out  1  write-strobe for mepc/mcause/mtval/mstatus fields below.
REQ-016 mepc_o / mcause_o / mtval_o  out  XLEN each  values to write.
REQ-017 mstatus_mie_o / mstatus_mpie_o  out  1 each  new mstatus.MIE / MPIE; mstatus_mpp_o out 2, always 2'b11.
REQ-018 stall_o  out  1  hold pipeline; flush_o out 1 kill younger instructions.
REQ-019 redirect_valid_o  out  1  redirect_pc_o out XLEN  fetch redirect.

Function
REQ-020 FSM states IDLE, SAVE, RESTORE, REDIRECT; events sampled only in IDLE with instr_valid_i=1.
REQ-021 Priority at one boundary: exc_valid_i > MEI (meip&meie&MIE) > MTI (mtip&mtie&MIE) > mret_i; lower events discarded that cycle.
REQ-022 Exception: IDLE->SAVE; captures cause=exc_cause_i, tval=exc_tval_i, epc=instr_pc_i.
REQ-023 Interrupt: IDLE->SAVE; cause=M_EXT_INT or M_TIMER_INT, tval=0, epc=instr_pc_i (instruction not executed).
REQ-024 MRET (no higher event): IDLE->RESTORE; captures target=mepc_i.
REQ-025 SAVE (1 cycle): csr_we_o=1, mepc_o/mcause_o/mtval_o=captured, mstatus_mpie_o=mstatus_mie_i, mstatus_mie_o=0; ->REDIRECT.
REQ-026 RESTORE (1 cycle): csr_we_o=1, mstatus_mie_o=mstatus_mpie_i, mstatus_mpie_o=1, mepc_o/mcause_o/mtval_o driven with current mepc_i/0/0 and ignored by CSR unit for MRET via csr_we_o field-qualifying not required; ->REDIRECT.
REQ-027 REDIRECT (1 cycle): redirect_valid_o=1, flush_o=1, redirect_pc_o=MTVEC (trap) or captured target (MRET); ->IDLE.
REQ-028 stall_o=1 in SAVE, RESTORE, REDIRECT; 0 in IDLE.
REQ-029 Latency: event at cycle N -> csr_we_o at N+1 -> redirect_valid_o at N+2 -> new event accepted at N+3.
REQ-030 All inputs ignored outside IDLE; interrupts arriving then are taken at next qualifying boundary if still pending and enabled.
REQ-031 mepc_o bits[1:0] forced to 0.
REQ-032 Outputs not listed active in a state are 0.

Reset
REQ-033 rst_n=0 at a clock edge: state=IDLE, all outputs 0, captured registers 0; reset mid-sequence aborts with no CSR write or redirect afterward.

Structure
REQ-034 Package gains trap_state_t enum; cause codes and HARDCODED_MTVEC reused from package.
REQ-035 One combinational sub-module trap_cause_sel: priority select of REQ-021 producing event kind and cause.

Verification
REQ-036 exc_valid_i=1, cause=M_ILL_INSTR, tval=32'h0000_0013, pc=32'h0000_0100, MIE=1 -> N+1 csr_we_o, mepc_o=32'h100, mcause_o=2, mtval_o=32'h13, mie_o=0, mpie_o=1; N+2 redirect_pc_o=32'h8000_0004.
REQ-037 meip_i=mtip_i=1, both enabled, MIE=1, pc=32'h200 -> mcause_o=32'h8000_000B, mtval_o=0, mepc_o=32'h200.
REQ-038 mtip_i=1, mie_mtie_i=1, MIE=0 -> no trap; stall_o stays 0.
REQ-039 mret_i=1, mepc_i=32'h0000_0104, MPIE=1 -> N+1 mstatus_mie_o=1, mpie_o=1; N+2 redirect_pc_o=32'h104.
REQ-040 exc_valid_i and mret_i same cycle -> exception path; separately, rst_n=0 during SAVE -> no redirect_valid_o, state IDLE.
